// File: rtl/binary_search_ctrl_pkg.sv
// Shared types and helpers for the binary-search controller that drives a
// magnitude comparator and recovers its target operand.
package binary_search_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A healthy comparator asserts exactly one of less/equal/greater.
    function automatic logic flags_onehot(input logic l, input logic e, input logic g);
        return (l ^ e ^ g) && !(l && e && g);
    endfunction

endpackage

// File: rtl/binary_search_ctrl.sv
// Binary-search FSM: drives guess onto the comparator, narrows [lo, hi] from
// the less/equal/greater flags, and reports found/error/result/compares.
//
//   state | meaning
//   IDLE  | waiting for start; outputs of the last search are held
//   CALC  | guess <= midpoint of [lo, hi]
//   CMP   | sample comparator flags, narrow bounds or finish
//   DONE  | one-cycle done pulse, then back to IDLE
module binary_search_ctrl
    import binary_search_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int CW = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    compares
);

    state_t         state;
    logic [WIDTH:0] lo;
    logic [WIDTH:0] hi;
    logic [WIDTH:0] lo_nxt;
    logic [WIDTH:0] hi_nxt;
    logic [WIDTH:0] mid_sum;
    logic [WIDTH:0] guess_ext;

    // Bounds carry one extra bit so guess-1 at 0 and guess+1 at max stay ordered.
    assign guess_ext = {1'b0, guess};
    assign mid_sum   = lo + hi;

    always_comb begin
        lo_nxt = lo;
        hi_nxt = hi;
        if (less) begin
            lo_nxt = guess_ext + (WIDTH + 1)'(1);
        end else if (greater) begin
            hi_nxt = guess_ext - (WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '0;
            guess    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            error    <= 1'b0;
            result   <= '0;
            compares <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lo       <= '0;
                        hi       <= {1'b0, {WIDTH{1'b1}}};
                        compares <= '0;
                        found    <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    guess <= mid_sum[WIDTH:1];
                    state <= CMP;
                end
                CMP: begin
                    compares <= compares + CW'(1);
                    if (!flags_onehot(less, equal, greater)) begin
                        error <= 1'b1;
                        found <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (equal) begin
                        found  <= 1'b1;
                        result <= guess;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        lo <= lo_nxt;
                        hi <= hi_nxt;
                        if ($signed(lo_nxt) > $signed(hi_nxt)) begin
                            found <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Directed bench for binary_search_ctrl with a behavioural 4-bit comparator
// closing the loop between guess and target.
module tb_binary_search_ctrl;
    import binary_search_ctrl_pkg::*;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 2);

    logic             clk;
    logic             rst;
    logic             start;
    logic             less;
    logic             equal;
    logic             greater;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             found;
    logic             error;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    compares;

    logic [WIDTH-1:0] target;
    logic             force_bad;
    logic [WIDTH-1:0] gseq[$];
    int               vectors;
    int               miscompares;
    int               cyc;
    int               exp_cmp[16];

    binary_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .less(less), .equal(equal), .greater(greater),
        .guess(guess), .busy(busy), .done(done), .found(found),
        .error(error), .result(result), .compares(compares)
    );

    assign less    = force_bad ? 1'b0 : (guess <  target);
    assign equal   = force_bad ? 1'b0 : (guess == target);
    assign greater = force_bad ? 1'b0 : (guess >  target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Raises start at posedge+1 in IDLE; cyc counts edges from the sampling
    // edge until done is seen; guesses are recorded after every CALC edge.
    task automatic run_search(input logic [WIDTH-1:0] t, input int mid_start_at);
        @(posedge clk); #1;
        target = t;
        gseq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            start = (cyc == mid_start_at);
            @(posedge clk); #1;
            cyc++;
            if (cyc % 2 == 0 && done !== 1'b1) gseq.push_back(guess);
        end
        start = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: target=%0d done=%b after %0d cycles", t, done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; target = '0; force_bad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({guess, busy, done, found, error, result, compares} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: guess=%0d busy=%b done=%b found=%b error=%b result=%0d compares=%0d, want all 0",
                     guess, busy, done, found, error, result, compares);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_compare();
        run_search(4'd7, -1);
        vectors++;
        if (cyc !== 3) begin miscompares++; $display("FAIL t7_latency: got %0d want 3", cyc); end
        vectors++;
        if ({found, error, busy, result, compares, guess} !== {1'b1, 1'b0, 1'b0, 4'd7, 3'd1, 4'd7}) begin
            miscompares++;
            $display("FAIL t7_outputs: found=%b error=%b busy=%b result=%0d compares=%0d guess=%0d, want 1 0 0 7 1 7",
                     found, error, busy, result, compares, guess);
        end
        // start held during the done cycle must not launch a new search
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if ({done, found, result} !== {1'b0, 1'b1, 4'd7}) begin
            miscompares++;
            $display("FAIL t7_after_done: done=%b found=%b result=%0d, want 0 1 7", done, found, result);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL start_in_done_ignored: busy=%b want 0", busy); end
    endtask

    task automatic test_top_edge();
        run_search(4'd15, -1);
        vectors++;
        if (cyc !== 11) begin miscompares++; $display("FAIL t15_latency: got %0d want 11", cyc); end
        vectors++;
        if (gseq.size() != 5 || gseq[0] !== 4'd7 || gseq[1] !== 4'd11 || gseq[2] !== 4'd13 ||
            gseq[3] !== 4'd14 || gseq[4] !== 4'd15) begin
            miscompares++;
            $display("FAIL t15_guess_seq: got %p want 7 11 13 14 15", gseq);
        end
        vectors++;
        if ({found, result, compares} !== {1'b1, 4'd15, 3'd5}) begin
            miscompares++;
            $display("FAIL t15_outputs: found=%b result=%0d compares=%0d, want 1 15 5", found, result, compares);
        end
    endtask

    task automatic test_bad_flags();
        force_bad = 1'b1;
        run_search(4'd5, -1);
        force_bad = 1'b0;
        vectors++;
        if (cyc !== 3) begin miscompares++; $display("FAIL bad_latency: got %0d want 3", cyc); end
        vectors++;
        if ({error, found, result, compares} !== {1'b1, 1'b0, 4'd15, 3'd1}) begin
            miscompares++;
            $display("FAIL bad_outputs: error=%b found=%b result=%0d compares=%0d, want 1 0 15 1",
                     error, found, result, compares);
        end
    endtask

    task automatic test_bottom_edge();
        run_search(4'd0, -1);
        vectors++;
        if (cyc !== 9) begin miscompares++; $display("FAIL t0_latency: got %0d want 9", cyc); end
        vectors++;
        if (gseq.size() != 4 || gseq[0] !== 4'd7 || gseq[1] !== 4'd3 || gseq[2] !== 4'd1 || gseq[3] !== 4'd0) begin
            miscompares++;
            $display("FAIL t0_guess_seq: got %p want 7 3 1 0", gseq);
        end
        vectors++;
        if ({found, error, result, compares} !== {1'b1, 1'b0, 4'd0, 3'd4}) begin
            miscompares++;
            $display("FAIL t0_outputs: found=%b error=%b result=%0d compares=%0d, want 1 0 0 4",
                     found, error, result, compares);
        end
    endtask

    task automatic test_ignored_start();
        run_search(4'd8, 4);
        vectors++;
        if ({cyc == 9, found, result, compares} !== {1'b1, 1'b1, 4'd8, 3'd4}) begin
            miscompares++;
            $display("FAIL t8_midstart: cyc=%0d found=%b result=%0d compares=%0d, want 9 1 8 4",
                     cyc, found, result, compares);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL t8_no_queue: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        target = 4'd13;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({guess, busy, done, found, error, result, compares} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: guess=%0d busy=%b done=%b found=%b error=%b result=%0d compares=%0d, want all 0",
                     guess, busy, done, found, error, result, compares);
        end
        run_search(4'd13, -1);
        vectors++;
        if ({cyc == 7, found, result, compares} !== {1'b1, 1'b1, 4'd13, 3'd3}) begin
            miscompares++;
            $display("FAIL midreset_rerun: cyc=%0d found=%b result=%0d compares=%0d, want 7 1 13 3",
                     cyc, found, result, compares);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 16; t++) begin
            run_search(4'(t), -1);
            vectors++;
            if (found !== 1'b1 || result !== 4'(t) || int'(compares) != exp_cmp[t] ||
                cyc != 2 * exp_cmp[t] + 1 || compares > 3'd5) begin
                miscompares++;
                $display("FAIL sweep_t%0d: found=%b result=%0d compares=%0d cyc=%0d, want 1 %0d %0d %0d",
                         t, found, result, compares, cyc, t, exp_cmp[t], 2 * exp_cmp[t] + 1);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_cmp = '{4, 3, 4, 2, 4, 3, 4, 1, 4, 3, 4, 2, 4, 3, 4, 5};
        test_reset();
        test_single_compare();
        test_top_edge();
        test_bad_flags();
        test_bottom_edge();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
